// File: rtl/srdl2sv_rsp_tracker.sv
// srdl2sv_rsp_tracker
// Tracks one register-bus transaction at a time: accepts a read or write
// request pulse, waits for any per-register acknowledge (or times out) and
// returns a single-cycle response pulse with error flag and read data.
//
// Ports
//   reg_clk      : clock, all state on rising edge
//   reg_rst      : synchronous active-high reset
//   w_vld/r_vld  : write/read request pulses from the bus widget
//   reg_ack      : per-register acknowledge [N_REGS]
//   reg_err      : per-register error, qualified by reg_ack [N_REGS]
//   reg_rd_data  : per-register read data, slice i = [32*i+31:32*i]
//   rsp_vld      : one-cycle response pulse
//   rsp_err      : response error (valid with rsp_vld)
//   rsp_data     : response read data (valid with rsp_vld)
//   busy         : transaction in flight (WAIT or RESP)
//   req_ovf      : sticky, a request arrived while busy
module srdl2sv_rsp_tracker #(
   parameter int N_REGS         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  reg_clk,
   input  logic                  reg_rst,
   input  logic                  w_vld,
   input  logic                  r_vld,
   input  logic [N_REGS-1:0]     reg_ack,
   input  logic [N_REGS-1:0]     reg_err,
   input  logic [32*N_REGS-1:0]  reg_rd_data,
   output logic                  rsp_vld,
   output logic                  rsp_err,
   output logic [31:0]           rsp_data,
   output logic                  busy,
   output logic                  req_ovf
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            r_is_rd;
   logic            r_rsp_err;
   logic [31:0]     r_rsp_data;
   logic            r_req_ovf;

   logic            w_ack_any;
   logic            w_ack_multi;
   logic            w_ack_err;
   logic [31:0]     w_mux_data;
   logic            w_timeout;
   logic            w_req_one;
   logic            w_req_both;
   logic [N_REGS-1:0] w_ack_m1;

   assign w_ack_any   = |reg_ack;
   // Clearing the lowest set bit leaves something only if two or more bits are set.
   assign w_ack_m1    = reg_ack - N_REGS'(1);
   assign w_ack_multi = |(reg_ack & w_ack_m1);
   assign w_ack_err   = (|(reg_ack & reg_err)) | w_ack_multi;
   assign w_timeout   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_req_one   = w_vld ^ r_vld;
   assign w_req_both  = w_vld & r_vld;

   // AND-OR mux: only meaningful when exactly one ack bit is set.
   always_comb begin
      w_mux_data = '0;
      for (int i = 0; i < N_REGS; i++) begin
         w_mux_data = w_mux_data | (reg_rd_data[32*i +: 32] & {32{reg_ack[i]}});
      end
   end

   // State register
   always_ff @(posedge reg_clk) begin
      if (reg_rst) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_req_both)                  w_next = RESP;
            else if (w_req_one)              w_next = w_ack_any ? RESP : WAIT;
         end
         WAIT: begin
            if (w_ack_any || w_timeout)      w_next = RESP;
         end
         RESP:                               w_next = IDLE;
         default:                            w_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      rsp_vld  = (r_state == RESP);
      busy     = (r_state != IDLE);
      rsp_err  = r_rsp_err;
      rsp_data = r_rsp_data;
      req_ovf  = r_req_ovf;
   end

   // Transaction datapath: counter, op type, response capture, overflow flag
   always_ff @(posedge reg_clk) begin
      if (reg_rst) begin
         r_cnt      <= '0;
         r_is_rd    <= 1'b0;
         r_rsp_err  <= 1'b0;
         r_rsp_data <= '0;
         r_req_ovf  <= 1'b0;
      end else begin
         if ((r_state != IDLE) && (w_vld || r_vld)) r_req_ovf <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_req_both) begin
                  r_rsp_err  <= 1'b1;
                  r_rsp_data <= '0;
               end else if (w_req_one) begin
                  r_is_rd <= r_vld;
                  r_cnt   <= '0;
                  if (w_ack_any) begin
                     r_rsp_err  <= w_ack_err;
                     r_rsp_data <= (r_vld && !w_ack_err) ? w_mux_data : 32'd0;
                  end
               end
            end
            WAIT: begin
               // Ack takes priority over a coincident timeout.
               if (w_ack_any) begin
                  r_rsp_err  <= w_ack_err;
                  r_rsp_data <= (r_is_rd && !w_ack_err) ? w_mux_data : 32'd0;
               end else if (w_timeout) begin
                  r_rsp_err  <= 1'b1;
                  r_rsp_data <= '0;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
